ks_adder_rr_sched: RTL and testbench
====================================

// Module: ks_adder_rr_sched
// PURPOSE
//  Round-robin scheduler sharing one Kogge-Stone prefix adder among NREQ requesters.
//  - Per-requester valid/ready request channel.
//  - 2-stage pipeline: stage S1 holds the registered operands; stage S2 holds the registered sum.
//  - Single valid/ready response channel tagged with the requester ID.
//  - Sits between the arithmetic clients and the shared adder datapath.
// PARAMETERS
//  WIDTH  19  operand/sum bit width (>=2)
//  NREQ    4  requester count (2..16)
//  IDW    $clog2(NREQ)  localparam, response ID width
// PORTS
//  clk        in   1           clock, all state on rising edge
//  rst_n      in   1           asynchronous active-low reset
//  req_valid  in   NREQ        request i valid
//  req_ready  out  NREQ        request i accepted this cycle (one-hot or zero)
//  req_a      in   NREQ*WIDTH  operand A, slice i = [i*WIDTH +: WIDTH]
//  req_b      in   NREQ*WIDTH  operand B, same slicing
//  req_cin    in   NREQ        carry-in per requester
//  req_sub    in   NREQ        subtract select (present only with KS_SCHED_SUB_EN)
//  rsp_valid  out  1           result valid
//  rsp_ready  in   1           consumer accepts result
//  rsp_sum    out  WIDTH       sum bits
//  rsp_cout   out  1           carry out
//  rsp_id     out  IDW         index of the originating requester
//  busy       out  1           S1 or S2 occupied
// BEHAVIOUR
//  - Reset (async, rst_n=0): s1_vld=0, s2_vld=0, rr_ptr=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0.
//    In-flight ops are discarded. req_ready=0 while rst_n=0.
//  - adv2 = !s2_vld | rsp_ready.
//  - adv1 = !s1_vld | adv2.
//  - Grant: combinational, only when adv1=1.
//    First requester with req_valid set, searching rr_ptr, rr_ptr+1, ... mod NREQ.
//    req_ready = one-hot grant. req_ready[i] does not depend on req_valid[j] for j != i beyond the priority search.
//  - Accept on edge k (req_valid[i] & req_ready[i]): S1 <= {a, b, cin, i}; rr_ptr <= (i+1) mod NREQ.
//    rr_ptr is unchanged when nothing is granted.
//  - S1 -> S2 on edge when s1_vld & adv2: {rsp_cout, rsp_sum} <= a + b + cin, full WIDTH+1-bit result.
//    rsp_id <= the S1 ID.
//  - Latency: accept at edge k gives rsp_valid=1 after edge k+1, with rsp_ready held high.
//    Throughput is 1 op/cycle.
//  - Backpressure: rsp_ready=0 with S2 full holds rsp_* stable; S1 fills and stalls; then all req_ready=0.
//    No data is lost or duplicated.
//  - Simultaneous events: S2 drain and S1 refill happen on the same edge; S1 refill and a new grant happen on the same edge.
//  - Wrap-around: A=2^WIDTH-1, B=0, cin=1 gives sum=0, cout=1.
//    rr_ptr wraps NREQ-1 -> 0.
//  - rsp_* outputs are registered. req_ready is combinational from req_valid, the pipeline state and rr_ptr.
// CONFIGURATION
//  KS_SCHED_SUB_EN defined:
//   - req_sub port exists. Latched into S1.
//   - Adder operand B = sub ? ~b : b. Carry-in = sub ? 1 : cin; req_cin is ignored for sub ops.
//   - rsp_cout = 1 means no borrow.
//  KS_SCHED_SUB_EN undefined:
//   - Port absent. Add only.
// STRUCTURE
//  - Package ks_sched_pkg: default-WIDTH constant; S1 entry struct {a, b, cin, sub, id}; rr_next() function.
//  - Sub-module ks_prefix_add:
//   - Combinational Kogge-Stone adder, parameter WIDTH, ports A, B, cin, S, cout.
//   - Instantiated once, between S1 and S2.
//  - Scheduler body: arbiter, S1/S2 registers, handshake logic.
// TESTING
//  1. Reset mid-stream: rst_n=0 while S1 and S2 are full. All outputs go to 0 at once. After release, the first grant goes to requester 0.
//  2. Single op, rsp_ready=1: req 2 sends A=0x12345, B=0x0ABCD, cin=1. rsp_valid rises 2 edges later with sum=0x1CF13, cout=0, id=2.
//  3. Overflow: A=0x7FFFF, B=0x00001, cin=0 -> sum=0, cout=1. A=0x7FFFF, B=0x7FFFF, cin=1 -> sum=0x7FFFF, cout=1.
//  4. Fairness: all 4 requesters hold valid for 8 cycles, rsp_ready=1. Grants go 0,1,2,3,0,1,2,3. rsp_id follows that order, 1 op/cycle.
//  5. Backpressure: rsp_ready=0 for 5 cycles with continuous requests. Exactly 2 ops are accepted, then req_ready=0 and rsp_* stay stable. After release the results drain in order.
//  6. KS_SCHED_SUB_EN: A=0x00005, B=0x00007, sub=1 -> sum=0x7FFFE, cout=0. A=7, B=5 -> sum=2, cout=1.
//  Every test: compare against a scoreboard of A+B+cin (or A-B) per ID.

Source files
------------

// File: rtl/ks_adder_rr_sched_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
// Default width, S1 entry layout and round-robin pointer step.
package ks_sched_pkg;

  localparam int KS_WIDTH   = 19;
  localparam int KS_IDW_MAX = 4;

  typedef struct packed {
    logic [KS_WIDTH-1:0]   a;
    logic [KS_WIDTH-1:0]   b;
    logic                  cin;
    logic                  sub;
    logic [KS_IDW_MAX-1:0] id;
  } ks_s1_t;

  function automatic logic [KS_IDW_MAX-1:0] rr_next(
    input logic [KS_IDW_MAX-1:0] cur,
    input int                    nreq
  );
    if (int'(cur) >= nreq - 1) return '0;
    return cur + 4'd1;
  endfunction

endpackage

// File: rtl/ks_adder_rr_sched_if.sv
// Request/response bundle of the shared-adder scheduler.
// master = clients/consumer side, slave = scheduler side; req_sub only with KS_SCHED_SUB_EN.
interface ks_adder_rr_sched_if
  import ks_sched_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
`ifdef KS_SCHED_SUB_EN
  logic [NREQ-1:0]       req_sub;
`endif
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, req_cin,
`ifdef KS_SCHED_SUB_EN
    output req_sub,
`endif
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_sum,
    input  rsp_cout, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin,
`ifdef KS_SCHED_SUB_EN
    input  req_sub,
`endif
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_sum,
    output rsp_cout, rsp_id, busy
  );

endinterface

// File: rtl/ks_adder_rr_sched_prefix_add.sv
// Combinational Kogge-Stone prefix adder.
// Ports: A, B, cin in; S sum, cout carry out.
module ks_prefix_add #(
  parameter int WIDTH = 19
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             cout
);

  localparam int LV = (WIDTH < 2) ? 1 : $clog2(WIDTH);

  logic [WIDTH-1:0] g [LV+1];
  logic [WIDTH-1:0] p [LV+1];
  logic [WIDTH:0]   c;

  assign g[0] = A & B;
  assign p[0] = A ^ B;

  for (genvar lv = 1; lv <= LV; lv++) begin : g_lvl
    localparam int D = 1 << (lv - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_op
        assign g[lv][i] = g[lv-1][i]
                        | (p[lv-1][i] & g[lv-1][i-D]);
        assign p[lv][i] = p[lv-1][i] & p[lv-1][i-D];
      end else begin : g_pass
        assign g[lv][i] = g[lv-1][i];
        assign p[lv][i] = p[lv-1][i];
      end
    end
  end

  // Group G/P over [i:0] fold in cin as a carry into bit 0.
  assign c[0]       = cin;
  assign c[WIDTH:1] = g[LV] | (p[LV] & {WIDTH{cin}});
  assign S          = p[0] ^ c[WIDTH-1:0];
  assign cout       = c[WIDTH];

endmodule

// File: rtl/ks_adder_rr_sched.sv
// Round-robin scheduler sharing one Kogge-Stone adder, 2-stage pipeline.
// Ports: clk, rst_n, bus (slave). Option macro: KS_SCHED_SUB_EN (subtract).
module ks_adder_rr_sched
  import ks_sched_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH,
  parameter int NREQ  = 4
) (
  input logic                clk,
  input logic                rst_n,
  ks_adder_rr_sched_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [IDW-1:0]   id;
  } s1_t;

  s1_t              s1;
  logic             s1_vld;
  logic             s2_vld;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   rr_ptr;

  logic             adv1;
  logic             adv2;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic             found;
  int               idx;

  logic [WIDTH-1:0] add_b;
  logic             add_c;
  logic [WIDTH-1:0] add_s;
  logic             add_co;

  assign adv2 = !s2_vld | bus.rsp_ready;
  assign adv1 = !s1_vld | adv2;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
    if (!adv1 || !rst_n) gnt = '0;
  end

  assign add_b = s1.sub ? ~s1.b : s1.b;
  assign add_c = s1.sub | s1.cin;

  ks_prefix_add #(.WIDTH(WIDTH)) u_add (
    .A    (s1.a),
    .B    (add_b),
    .cin  (add_c),
    .S    (add_s),
    .cout (add_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      id_q   <= '0;
      rr_ptr <= '0;
    end else begin
      if (adv1) begin
        s1_vld <= |gnt;
        if (|gnt) begin
          s1.a   <= bus.req_a[int'(gnt_id)*WIDTH +: WIDTH];
          s1.b   <= bus.req_b[int'(gnt_id)*WIDTH +: WIDTH];
          s1.cin <= bus.req_cin[gnt_id];
`ifdef KS_SCHED_SUB_EN
          s1.sub <= bus.req_sub[gnt_id];
`else
          s1.sub <= 1'b0;
`endif
          s1.id  <= gnt_id;
          rr_ptr <= IDW'(rr_next(KS_IDW_MAX'(gnt_id), NREQ));
        end
      end
      if (adv2) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          sum_q  <= add_s;
          cout_q <= add_co;
          id_q   <= s1.id;
        end
      end
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = s2_vld;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_id    = id_q;
  assign bus.busy      = s1_vld | s2_vld;

endmodule

// File: tb/tb_ks_adder_rr_sched.sv
// Directed bench for ks_adder_rr_sched with an in-order scoreboard.
// Define KS_SCHED_SUB_EN to also exercise subtract ops.
module tb_ks_adder_rr_sched;
  import ks_sched_pkg::*;

  localparam int W = KS_WIDTH;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   n_acc;

  ks_s1_t sb [$];

  ks_adder_rr_sched_if #(.WIDTH(W), .NREQ(N)) bus ();

  ks_adder_rr_sched #(.WIDTH(W), .NREQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input ks_s1_t e);
    logic [W-1:0] bb;
    logic         cc;
    bb = e.sub ? ~e.b : e.b;
    cc = e.sub ? 1'b1 : e.cin;
    return {1'b0, e.a} + {1'b0, bb} + (W+1)'(cc);
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin,
                        input logic sub);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_cin[i]      = cin;
`ifdef KS_SCHED_SUB_EN
    bus.req_sub[i]      = sub;
`else
    if (sub) $display("note: sub ignored without KS_SCHED_SUB_EN");
`endif
  endtask

  // Scoreboard: retire responses first, then record new accepts.
  always @(negedge clk) begin
    if (rst_n) begin
      ks_s1_t     e;
      logic [W:0] r;
      chk("gnt_onehot0", 64'($onehot0(bus.req_ready)), 1);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_size", 64'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          r = model(e);
          chk("sb_sum", 64'(bus.rsp_sum), 64'(r[W-1:0]));
          chk("sb_cout", 64'(bus.rsp_cout), 64'(r[W]));
          chk("sb_id", 64'(bus.rsp_id), 64'(e.id));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          e.a   = bus.req_a[i*W +: W];
          e.b   = bus.req_b[i*W +: W];
          e.cin = bus.req_cin[i];
`ifdef KS_SCHED_SUB_EN
          e.sub = bus.req_sub[i];
`else
          e.sub = 1'b0;
`endif
          e.id  = KS_IDW_MAX'(i);
          sb.push_back(e);
          n_acc++;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic single_op(input string tag, input int id,
                           input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cin,
                           input logic sub,
                           input logic [W-1:0] es, input logic ec);
    set_op(id, a, b, cin, sub);
    bus.req_valid = 4'(1 << id);
    #1;
    chk({tag, "_gnt"}, 64'(bus.req_ready), 64'(1 << id));
    tick();
    bus.req_valid = '0;
    chk({tag, "_k1_vld"}, 64'(bus.rsp_valid), 0);
    tick();
    chk({tag, "_vld"}, 64'(bus.rsp_valid), 1);
    chk({tag, "_sum"}, 64'(bus.rsp_sum), 64'(es));
    chk({tag, "_cout"}, 64'(bus.rsp_cout), 64'(ec));
    chk({tag, "_id"}, 64'(bus.rsp_id), 64'(id));
    tick();
    chk({tag, "_idle"}, 64'(bus.busy), 0);
  endtask

  task automatic fair_ops(input int c);
    for (int i = 0; i < N; i++)
      set_op(i, W'(32'h01000 * (c + 1) + i),
             W'(32'h00333 * i + c), 1'(c), 1'b0);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    n_acc         = 0;
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
`ifdef KS_SCHED_SUB_EN
    bus.req_sub   = '0;
`endif
    bus.rsp_ready = 1'b1;
    #1;
    chk("rst_ready", 64'(bus.req_ready), 0);
    chk("rst_vld", 64'(bus.rsp_valid), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    tick();
    tick();
    bus.req_valid = '0;
    rst_n = 1'b1;
    tick();

    single_op("t2", 2, 19'h12345, 19'h0ABCD, 1'b1, 1'b0,
              19'h1CF13, 1'b0);
    single_op("t3a", 1, 19'h7FFFF, 19'h00001, 1'b0, 1'b0,
              19'h00000, 1'b1);
    single_op("t3b", 3, 19'h7FFFF, 19'h7FFFF, 1'b1, 1'b0,
              19'h7FFFF, 1'b1);
`ifdef KS_SCHED_SUB_EN
    single_op("t6a", 0, 19'h00005, 19'h00007, 1'b0, 1'b1,
              19'h7FFFE, 1'b0);
    single_op("t6b", 2, 19'h00007, 19'h00005, 1'b0, 1'b1,
              19'h00002, 1'b1);
`endif

    // Fill S1 and S2 under backpressure, then reset mid-stream.
    bus.rsp_ready = 1'b0;
    set_op(1, 19'h00100, 19'h00200, 1'b0, 1'b0);
    bus.req_valid = 4'b0010;
    tick();
    chk("t1_s1_gnt", 64'(bus.req_ready), 64'b0010);
    tick();
    chk("t1_full_vld", 64'(bus.rsp_valid), 1);
    chk("t1_full_busy", 64'(bus.busy), 1);
    chk("t1_full_rdy", 64'(bus.req_ready), 0);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t1_vld", 64'(bus.rsp_valid), 0);
    chk("t1_sum", 64'(bus.rsp_sum), 0);
    chk("t1_cout", 64'(bus.rsp_cout), 0);
    chk("t1_id", 64'(bus.rsp_id), 0);
    chk("t1_busy", 64'(bus.busy), 0);
    chk("t1_rdy", 64'(bus.req_ready), 0);
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    fair_ops(0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t1_first_gnt", 64'(bus.req_ready), 64'b0001);

    // Fairness: 8 grants 0,1,2,3,0,1,2,3, one per cycle.
    for (int c = 0; c < 10; c++) begin
      if (c < 8)
        chk("t4_gnt", 64'(bus.req_ready), 64'(1 << (c % 4)));
      if (c >= 2) begin
        chk("t4_vld", 64'(bus.rsp_valid), 1);
        chk("t4_id", 64'(bus.rsp_id), 64'((c - 2) % 4));
      end
      tick();
      if (c + 1 < 8) fair_ops(c + 1);
      else bus.req_valid = '0;
      #1;
    end
    chk("t4_idle_vld", 64'(bus.rsp_valid), 0);
    chk("t4_idle_busy", 64'(bus.busy), 0);

    // Backpressure: exactly two accepts, then everything holds.
    n_acc = 0;
    set_op(0, 19'h00010, 19'h00020, 1'b0, 1'b0);
    set_op(1, 19'h40000, 19'h40000, 1'b1, 1'b0);
    set_op(2, 19'h00003, 19'h00004, 1'b0, 1'b0);
    set_op(3, 19'h00005, 19'h00006, 1'b0, 1'b0);
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    #1;
    for (int j = 0; j < 5; j++) begin
      if (j == 0) chk("t5_gnt0", 64'(bus.req_ready), 64'b0001);
      if (j == 1) chk("t5_gnt1", 64'(bus.req_ready), 64'b0010);
      if (j >= 2) begin
        chk("t5_rdy", 64'(bus.req_ready), 0);
        chk("t5_vld", 64'(bus.rsp_valid), 1);
        chk("t5_sum", 64'(bus.rsp_sum), 64'h30);
        chk("t5_cout", 64'(bus.rsp_cout), 0);
        chk("t5_id", 64'(bus.rsp_id), 0);
      end
      tick();
      #1;
    end
    chk("t5_acc", 64'(n_acc), 2);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("t5_d_vld", 64'(bus.rsp_valid), 1);
    chk("t5_d_sum", 64'(bus.rsp_sum), 64'h1);
    chk("t5_d_cout", 64'(bus.rsp_cout), 1);
    chk("t5_d_id", 64'(bus.rsp_id), 1);
    tick();
    chk("t5_end_vld", 64'(bus.rsp_valid), 0);
    chk("t5_end_busy", 64'(bus.busy), 0);
    chk("t5_acc_end", 64'(n_acc), 2);
    chk("sb_left", 64'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
